// File: rtl/ps2_rx_axis_fifo_pkg.sv
// Shared PS/2 receiver definitions: frame constants, FSM states, frame payload type.
package ps2_rx_axis_fifo_pkg;

   localparam int unsigned PS2_FRAME_BITS  = 11;
   localparam int unsigned SCAN_W          = 8;
   localparam int unsigned DATA_BITS       = PS2_FRAME_BITS - 3;
   localparam int unsigned FILTER_LEN_DEF  = 16;
   localparam int unsigned TIMEOUT_CYC_DEF = 100000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   // Payload collected while a frame is open
   typedef struct packed {
      logic [SCAN_W-1:0] data;
      logic              parity;
   } ps2_frame_t;

   // PS/2 uses odd parity over the eight data bits plus the parity bit
   function automatic logic odd_parity_ok(input ps2_frame_t f);
      return ^{f.data, f.parity};
   endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with an AXI-stream style master side; all outputs are flops.
module axis_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             s_valid,
   input  logic [WIDTH-1:0] s_data,
   output logic             full,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d, after_pop_c;
   logic [WIDTH-1:0] head_d;
   logic             pop_c, push_c;

   // Handshake decode, next occupancy and the value that will sit at the head
   always_comb begin
      pop_c       = m_valid & m_ready;
      push_c      = s_valid & (~full | pop_c);
      count_d     = count_q + CW'(push_c) - CW'(pop_c);
      rd_ptr_d    = rd_ptr_q + AW'(pop_c);
      after_pop_c = count_q - CW'(pop_c);
      head_d      = '0;
      if (count_d != '0) begin
         // An entry written this cycle into an otherwise empty FIFO bypasses the array
         head_d = (after_pop_c == '0) ? s_data : mem_q[rd_ptr_d];
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk_i) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= s_data;
      end
   end

   // Pointers, occupancy and registered master-side outputs
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full     <= 1'b0;
         m_valid  <= 1'b0;
         m_data   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + AW'(push_c);
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full     <= (count_d == CW'(DEPTH));
         m_valid  <= (count_d != '0);
         m_data   <= head_d;
      end
   end

endmodule

// File: rtl/ps2_rx_axis_fifo.sv
// PS/2 device-to-host receiver: pin conditioning, frame decode, scancode FIFO on AXIS.
module ps2_rx_axis_fifo
   import ps2_rx_axis_fifo_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned FILTER_LEN  = FILTER_LEN_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ps2_clk_i,
   input  logic              ps2_data_i,
   input  logic              m_axis_tready_i,
   output logic              m_axis_tvalid_o,
   output logic [SCAN_W-1:0] m_axis_tdata_o,
   output logic              err_parity_o,
   output logic              err_frame_o,
   output logic              overflow_o
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned BW = $clog2(DATA_BITS);

   logic [1:0]    clk_sync_q, dat_sync_q;
   logic          flt_q, flt_prev_q;
   logic [FW-1:0] flt_cnt_q;
   logic [TW-1:0] to_cnt_q;
   logic          se_c, dat_c, timeout_c, pop_c, fifo_full;

   ps2_state_e    state_q, state_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   ps2_frame_t    frame_q, frame_d;
   logic          push_req_q, push_req_d;
   logic          err_parity_d, err_frame_d;

   assign se_c      = flt_prev_q & ~flt_q;
   assign dat_c     = dat_sync_q[1];
   assign timeout_c = (state_q != ST_IDLE) && (to_cnt_q == TW'(TIMEOUT_CYC));
   assign pop_c     = m_axis_tvalid_o & m_axis_tready_i;

   // Two-flop synchronisers; idle bus level is high
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
         dat_sync_q <= {dat_sync_q[0], ps2_data_i};
      end
   end

   // Glitch filter: accept a new clock level after FILTER_LEN consecutive differing samples
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         flt_q      <= 1'b1;
         flt_prev_q <= 1'b1;
         flt_cnt_q  <= '0;
      end else begin
         flt_prev_q <= flt_q;
         if (clk_sync_q[1] == flt_q) begin
            flt_cnt_q <= '0;
         end else if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
            flt_q     <= clk_sync_q[1];
            flt_cnt_q <= '0;
         end else begin
            flt_cnt_q <= flt_cnt_q + FW'(1);
         end
      end
   end

   // Inactivity counter for open frames
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         to_cnt_q <= '0;
      end else if (se_c || (state_q == ST_IDLE) || timeout_c) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_q + TW'(1);
      end
   end

   // Frame FSM state register, push request and error pulses
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         frame_q      <= '0;
         push_req_q   <= 1'b0;
         err_parity_o <= 1'b0;
         err_frame_o  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         frame_q      <= frame_d;
         push_req_q   <= push_req_d;
         err_parity_o <= err_parity_d;
         err_frame_o  <= err_frame_d;
      end
   end

   // Frame FSM next state: advances on sample events, timeout aborts any open frame
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      frame_d      = frame_q;
      push_req_d   = 1'b0;
      err_parity_d = 1'b0;
      err_frame_d  = 1'b0;
      if (timeout_c) begin
         state_d     = ST_IDLE;
         err_frame_d = 1'b1;
      end else if (se_c) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!dat_c) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end
            end
            ST_DATA: begin
               frame_d.data = {dat_c, frame_q.data[SCAN_W-1:1]};
               bit_cnt_d    = bit_cnt_q + BW'(1);
               if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                  state_d = ST_PARITY;
               end
            end
            ST_PARITY: begin
               frame_d.parity = dat_c;
               state_d        = ST_STOP;
            end
            ST_STOP: begin
               push_req_d   = dat_c & odd_parity_ok(frame_q);
               err_frame_d  = ~dat_c;
               err_parity_d = ~odd_parity_ok(frame_q);
               state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Overflow pulse: a good byte arrived while the FIFO was full and not draining
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         overflow_o <= 1'b0;
      end else begin
         overflow_o <= push_req_q & fifo_full & ~pop_c;
      end
   end

   axis_sync_fifo #(
      .WIDTH (SCAN_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .s_valid (push_req_q),
      .s_data  (frame_q.data),
      .full    (fifo_full),
      .m_valid (m_axis_tvalid_o),
      .m_ready (m_axis_tready_i),
      .m_data  (m_axis_tdata_o)
   );

endmodule
